instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I encoder for OP-IMM / LUI / AUIPC records, followed by an in-order output queue.
// Records that cannot be encoded still take a queue slot, carrying a zero word and an illegal flag.
package instr_encoder_pkg;
    typedef enum logic [1:0] {
        OK_OP_IMM   = 2'd0,
        OK_OP_LUI   = 2'd1,
        OK_OP_AUIPC = 2'd2
    } t_op_kind;

    typedef enum logic [3:0] {
        FK_ADD  = 4'd0,
        FK_SUB  = 4'd1,
        FK_SLL  = 4'd2,
        FK_SLT  = 4'd3,
        FK_SLTU = 4'd4,
        FK_XOR  = 4'd5,
        FK_SRL  = 4'd6,
        FK_SRA  = 4'd7,
        FK_OR   = 4'd8,
        FK_AND  = 4'd9
    } t_func_kind;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  t_op_kind                      in_kind,
    input  t_func_kind                    in_func,
    input  logic [4:0]                    in_rd,
    input  logic [4:0]                    in_rs1,
    input  logic [31:0]                   in_imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_word,
    output logic                          out_illegal,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   LVL_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]   DEPTH_LVL = (AW+1)'(FIFO_DEPTH);

    logic [2:0]    funct3_s;
    logic          is_shift_s;
    logic          func_ok_s;
    logic [31:0]   enc_word_s;
    logic          enc_illegal_s;
    logic          push_s;
    logic          pop_s;
    logic [32:0]   head_s;

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          ready_en_r;
    logic [32:0]   mem_r [FIFO_DEPTH];

    // Map the ALU function to funct3 and classify it as shift / non-shift / unencodable.
    always_comb begin
        funct3_s   = 3'b000;
        is_shift_s = 1'b0;
        func_ok_s  = 1'b1;
        case (in_func)
            FK_ADD:  funct3_s = 3'b000;
            FK_SLL:  begin funct3_s = 3'b001; is_shift_s = 1'b1; end
            FK_SLT:  funct3_s = 3'b010;
            FK_SLTU: funct3_s = 3'b011;
            FK_XOR:  funct3_s = 3'b100;
            FK_SRL:  begin funct3_s = 3'b101; is_shift_s = 1'b1; end
            FK_SRA:  begin funct3_s = 3'b101; is_shift_s = 1'b1; end
            FK_OR:   funct3_s = 3'b110;
            FK_AND:  funct3_s = 3'b111;
            default: func_ok_s = 1'b0;
        endcase
    end

    // Build the instruction word; any illegal record leaves the word at zero.
    always_comb begin
        enc_word_s    = 32'h0000_0000;
        enc_illegal_s = 1'b0;
        case (in_kind)
            OK_OP_IMM: begin
                if (!func_ok_s) begin
                    enc_illegal_s = 1'b1;
                end else if (is_shift_s) begin
                    if (in_imm[31:5] != 27'd0) begin
                        enc_illegal_s = 1'b1;
                    end else begin
                        enc_word_s = {1'b0, (in_func == FK_SRA), 5'b00000, in_imm[4:0],
                                      in_rs1, funct3_s, in_rd, 7'b0010011};
                    end
                end else begin
                    // The 12-bit immediate is sign-extended, so bits 31..11 must all match.
                    if (in_imm[31:11] != {21{in_imm[11]}}) begin
                        enc_illegal_s = 1'b1;
                    end else begin
                        enc_word_s = {in_imm[11:0], in_rs1, funct3_s, in_rd, 7'b0010011};
                    end
                end
            end
            OK_OP_LUI, OK_OP_AUIPC: begin
                if (in_imm[11:0] != 12'h000) begin
                    enc_illegal_s = 1'b1;
                end else begin
                    enc_word_s = {in_imm[31:12], in_rd,
                                  (in_kind == OK_OP_LUI) ? 7'b0110111 : 7'b0010111};
                end
            end
            default: enc_illegal_s = 1'b1;
        endcase
    end

    assign in_ready  = ready_en_r && (level_r < DEPTH_LVL);
    assign out_valid = (level_r != LVL_ZERO);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign head_s    = mem_r[rd_ptr_r];
    assign out_word    = out_valid ? head_s[31:0] : 32'h0000_0000;
    assign out_illegal = out_valid ? head_s[32]   : 1'b0;
    assign level       = level_r;

    // Queue pointers, occupancy and the post-reset input enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= LVL_ZERO;
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Queue storage; contents are only visible while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {enc_illegal_s, enc_word_s};
        end
    end

endmodule
